// File: rtl/bcd_sched_pkg.sv
// Shared types, state encodings and the round-robin pick function for the BCD adder scheduler.
package bcd_sched_pkg;

  localparam int unsigned N_REQ_MAX = 8;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t IDLE   = 2'd0;
  localparam sched_state_t LAUNCH = 2'd1;
  localparam sched_state_t WAIT   = 2'd2;
  localparam sched_state_t RESP   = 2'd3;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [N_REQ_MAX-1:0] req,
                                       input logic [2:0]           ptr,
                                       input int unsigned          n);
    rr_pick_t   res;
    logic [2:0] idx;
    res = '0;
    for (int unsigned off = 0; off < N_REQ_MAX; off++) begin
      idx = 3'((32'(ptr) + off) % n);
      if (!res.found && (off < n) && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_adder_scheduler_if.sv
// Requester, response and datapath bundle of the BCD adder scheduler.
// slave: scheduler side; master: clients plus datapath side.
interface bcd_adder_scheduler_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DIGITS = 8
);
  localparam int unsigned W = 4 * DIGITS;

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] op_a;
  logic [N_REQ*W-1:0] op_b;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   resp_valid;
  logic [N_REQ-1:0]   resp_ready;
  logic [W-1:0]       resp_sum;
  logic               resp_carry;
  logic               resp_err;
  logic               busy;
  logic               dp_start;
  logic [W-1:0]       dp_a;
  logic [W-1:0]       dp_b;
  logic               dp_done;
  logic [W-1:0]       dp_sum;
  logic               dp_carry;

  modport slave (
    input  req, op_a, op_b, resp_ready, dp_done, dp_sum, dp_carry,
    output gnt, resp_valid, resp_sum, resp_carry, resp_err, busy, dp_start, dp_a, dp_b
  );

  modport master (
    output req, op_a, op_b, resp_ready, dp_done, dp_sum, dp_carry,
    input  gnt, resp_valid, resp_sum, resp_carry, resp_err, busy, dp_start, dp_a, dp_b
  );

endinterface

// File: rtl/bcd_rr_arbiter.sv
// Round-robin winner selection; rr_ptr moves past the winner only on an update strobe.
module bcd_rr_arbiter
  import bcd_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  output logic [2:0]       winner,
  output logic             found
);

  logic [2:0] rr_ptr_q, rr_ptr_d;
  rr_pick_t   pick;

  always_comb begin
    pick = rr_pick(N_REQ_MAX'(req), rr_ptr_q, N_REQ);
  end

  assign winner = pick.idx;
  assign found  = pick.found;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (update) begin
      rr_ptr_d = (pick.idx == 3'(N_REQ - 1)) ? 3'd0 : pick.idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/bcd_adder_scheduler.sv
// Round-robin scheduler sharing one BCD adder datapath among N_REQ requesters.
// Optional WAIT watchdog enabled by defining BCD_SCHED_WATCHDOG_EN.
module bcd_adder_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_adder_scheduler_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
    $error("N_REQ must be in 2..8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             dp_start_q, dp_start_d;
  logic [W-1:0]     dp_a_q, dp_a_d;
  logic [W-1:0]     dp_b_q, dp_b_d;
  logic [2:0]       owner_q, owner_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [W-1:0]     resp_sum_q, resp_sum_d;
  logic             resp_carry_q, resp_carry_d;
  logic             busy_q, busy_d;

  logic [2:0]           winner;
  logic                 found;
  logic                 arb_update;
  logic [N_REQ_MAX-1:0] ready_ext;

`ifdef BCD_SCHED_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic            resp_err_q, resp_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  assign ready_ext = N_REQ_MAX'(bus.resp_ready);

  bcd_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req),
    .update (arb_update),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = '0;
    dp_start_d   = 1'b0;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    owner_d      = owner_q;
    resp_valid_d = resp_valid_q;
    resp_sum_d   = resp_sum_q;
    resp_carry_d = resp_carry_q;
    arb_update   = 1'b0;
`ifdef BCD_SCHED_WATCHDOG_EN
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = LAUNCH;
          gnt_d      = N_REQ'(1) << winner;
          dp_start_d = 1'b1;
          dp_a_d     = bus.op_a[32'(winner) * W +: W];
          dp_b_d     = bus.op_b[32'(winner) * W +: W];
          owner_d    = winner;
          arb_update = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef BCD_SCHED_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.dp_done) begin
          state_d      = RESP;
          resp_sum_d   = bus.dp_sum;
          resp_carry_d = bus.dp_carry;
          resp_valid_d = N_REQ'(1) << owner_q;
`ifdef BCD_SCHED_WATCHDOG_EN
          resp_err_d   = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_sum_d   = '0;
          resp_carry_d = 1'b0;
          resp_err_d   = 1'b1;
          resp_valid_d = N_REQ'(1) << owner_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      RESP: begin
        if (ready_ext[owner_q]) begin
          state_d      = IDLE;
          resp_valid_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      dp_start_q   <= 1'b0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      owner_q      <= '0;
      resp_valid_q <= '0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      dp_start_q   <= dp_start_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      owner_q      <= owner_d;
      resp_valid_q <= resp_valid_d;
      resp_sum_q   <= resp_sum_d;
      resp_carry_q <= resp_carry_d;
      busy_q       <= busy_d;
    end
  end

`ifdef BCD_SCHED_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      resp_err_q <= resp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.resp_err = resp_err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.gnt        = gnt_q;
  assign bus.dp_start   = dp_start_q;
  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_carry = resp_carry_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bcd_adder_scheduler.sv
// Directed self-checking bench for bcd_adder_scheduler; the datapath is driven by hand.
// Watchdog cases run only when BCD_SCHED_WATCHDOG_EN is defined.
module tb_bcd_adder_scheduler;

  localparam int N = 4;
  localparam int D = 8;
  localparam int W = 4 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_adder_scheduler_if #(.N_REQ(N), .DIGITS(D)) bus ();

  bcd_adder_scheduler #(
    .N_REQ   (N),
    .DIGITS  (D),
    .TIMEOUT (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.op_a[i*W +: W] = a;
    bus.op_b[i*W +: W] = b;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 64'(bus.gnt), 0);
    check({tag, "_rv"}, 64'(bus.resp_valid), 0);
    check({tag, "_sum"}, 64'(bus.resp_sum), 0);
    check({tag, "_carry"}, 64'(bus.resp_carry), 0);
    check({tag, "_err"}, 64'(bus.resp_err), 0);
    check({tag, "_busy"}, 64'(bus.busy), 0);
    check({tag, "_start"}, 64'(bus.dp_start), 0);
    check({tag, "_dpa"}, 64'(bus.dp_a), 0);
    check({tag, "_dpb"}, 64'(bus.dp_b), 0);
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    while (bus.gnt == '0 && lat < 20) begin
      cyc();
      lat++;
    end
  endtask

  // One full job for requester w; datapath answers 4 cycles into WAIT.
  task automatic do_job(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sum, input logic carry, input bit keep,
                        input bit stray, output int lat);
    wait_gnt(lat);
    check("gnt", 64'(bus.gnt), 64'(1) << w);
    check("dp_start", 64'(bus.dp_start), 1);
    check("dp_a", 64'(bus.dp_a), 64'(a));
    check("dp_b", 64'(bus.dp_b), 64'(b));
    if (!keep) bus.req[w] = 1'b0;
    if (stray) begin
      bus.dp_done = 1'b1;
      bus.dp_sum  = 32'h1234_5678;
    end
    cyc();
    bus.dp_done = 1'b0;
    check("gnt_pulse", 64'(bus.gnt), 0);
    check("start_pulse", 64'(bus.dp_start), 0);
    check("busy_wait", 64'(bus.busy), 1);
    repeat (4) cyc();
    check("no_early_rv", 64'(bus.resp_valid), 0);
    bus.dp_done  = 1'b1;
    bus.dp_sum   = sum;
    bus.dp_carry = carry;
    cyc();
    bus.dp_done  = 1'b0;
    bus.dp_sum   = '0;
    bus.dp_carry = 1'b0;
    check("rv", 64'(bus.resp_valid), 64'(1) << w);
    check("sum", 64'(bus.resp_sum), 64'(sum));
    check("carry", 64'(bus.resp_carry), 64'(carry));
    check("err", 64'(bus.resp_err), 0);
    bus.resp_ready = N'(1) << w;
    cyc();
    bus.resp_ready = '0;
    check("rv_clr", 64'(bus.resp_valid), 0);
    check("busy_idle", 64'(bus.busy), 0);
    check("sum_kept", 64'(bus.resp_sum), 64'(sum));
    check("dpa_kept", 64'(bus.dp_a), 64'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    bus.req        = '0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.resp_ready = '0;
    bus.dp_done    = 1'b0;
    bus.dp_sum     = '0;
    bus.dp_carry   = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, 32'h0000_0010 + 32'(i), 32'h0000_0020 + 32'(i));

    #1 rst = 1'b0;
    #2;
    check_idle_outputs("reset");
    cyc();
    cyc();
    rst = 1'b1;

    // Single job with cycle-exact grant latency.
    set_ops(0, 32'h0000_0095, 32'h0000_0007);
    bus.req = 4'b0001;
    do_job(0, 32'h0000_0095, 32'h0000_0007, 32'h0000_0102, 1'b0, 1'b0, 1'b0, lat);
    check("gnt_latency", 64'(lat), 1);

    // Restart with rr_ptr at 0 for the fairness sequence.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    set_ops(0, 32'h0000_0010, 32'h0000_0020);

    bus.req = 4'b1111;
    do_job(0, 32'h10, 32'h20, 32'h30, 1'b0, 1'b1, 1'b0, lat);
    do_job(1, 32'h11, 32'h21, 32'h32, 1'b0, 1'b1, 1'b1, lat);
    do_job(2, 32'h12, 32'h22, 32'h34, 1'b0, 1'b1, 1'b0, lat);
    do_job(3, 32'h13, 32'h23, 32'h36, 1'b0, 1'b1, 1'b0, lat);
    do_job(0, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1'b0, lat);
    check("rr_next_gap", 64'(lat), 1);

    // rr_ptr now 1: grant 1, then with req=1010 and rr_ptr=2 the winner is 3.
    bus.req = 4'b0010;
    do_job(1, 32'h11, 32'h21, 32'h32, 1'b0, 1'b0, 1'b0, lat);
    bus.req = 4'b1010;
    do_job(3, 32'h13, 32'h23, 32'h36, 1'b0, 1'b0, 1'b0, lat);
    bus.req = '0;

    // Stray dp_done in IDLE.
    bus.dp_done = 1'b1;
    bus.dp_sum  = 32'h5555_5555;
    cyc();
    bus.dp_done = 1'b0;
    check("stray_idle_rv", 64'(bus.resp_valid), 0);
    check("stray_idle_busy", 64'(bus.busy), 0);
    check("stray_idle_sum", 64'(bus.resp_sum), 64'h36);

    // Carry result under backpressure while others request.
    set_ops(0, 32'h9999_9999, 32'h9999_9999);
    bus.req = 4'b0001;
    wait_gnt(lat);
    check("bp_gnt", 64'(bus.gnt), 64'b0001);
    check("bp_dpa", 64'(bus.dp_a), 64'h9999_9999);
    bus.req = 4'b1110;
    cyc();
    cyc();
    bus.dp_done  = 1'b1;
    bus.dp_sum   = 32'h9999_9998;
    bus.dp_carry = 1'b1;
    cyc();
    bus.dp_done  = 1'b0;
    bus.dp_carry = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.resp_ready = 4'b1110;
      cyc();
      check("bp_rv", 64'(bus.resp_valid), 64'b0001);
      check("bp_sum", 64'(bus.resp_sum), 64'h9999_9998);
      check("bp_carry", 64'(bus.resp_carry), 1);
      check("bp_no_gnt", 64'(bus.gnt), 0);
      check("bp_busy", 64'(bus.busy), 1);
    end
    bus.resp_ready = 4'b0001;
    cyc();
    bus.resp_ready = '0;
    check("bp_rv_clr", 64'(bus.resp_valid), 0);
    check("bp_carry_kept", 64'(bus.resp_carry), 1);
    do_job(1, 32'h11, 32'h21, 32'h32, 1'b0, 1'b0, 1'b0, lat);

    // Reset mid-WAIT with rr_ptr advanced to 3 beforehand.
    wait_gnt(lat);
    check("rst_pre_gnt", 64'(bus.gnt), 64'b0100);
    bus.req = '0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_wait");
    cyc();
    cyc();
    check("rst_hold_busy", 64'(bus.busy), 0);
    rst = 1'b1;
    bus.req = 4'b0101;
    do_job(0, 32'h9999_9999, 32'h9999_9999, 32'h9999_9998, 1'b1, 1'b0, 1'b0, lat);
    bus.req = 4'b0100;
    do_job(2, 32'h12, 32'h22, 32'h34, 1'b0, 1'b0, 1'b0, lat);

`ifdef BCD_SCHED_WATCHDOG_EN
    // Timeout: response 64 cycles after entering WAIT.
    bus.req = 4'b0010;
    wait_gnt(lat);
    check("wd_gnt", 64'(bus.gnt), 64'b0010);
    bus.req = '0;
    cyc();
    repeat (63) cyc();
    check("wd_not_yet", 64'(bus.resp_valid), 0);
    cyc();
    check("wd_rv", 64'(bus.resp_valid), 64'b0010);
    check("wd_err", 64'(bus.resp_err), 1);
    check("wd_sum", 64'(bus.resp_sum), 0);
    check("wd_carry", 64'(bus.resp_carry), 0);
    bus.resp_ready = 4'b0010;
    cyc();
    bus.resp_ready = '0;

    // dp_done on the last allowed cycle wins over the timeout.
    bus.req = 4'b0100;
    wait_gnt(lat);
    check("wd2_gnt", 64'(bus.gnt), 64'b0100);
    bus.req = '0;
    cyc();
    repeat (63) cyc();
    bus.dp_done  = 1'b1;
    bus.dp_sum   = 32'h0000_0777;
    bus.dp_carry = 1'b1;
    cyc();
    bus.dp_done  = 1'b0;
    bus.dp_carry = 1'b0;
    check("wd2_rv", 64'(bus.resp_valid), 64'b0100);
    check("wd2_err", 64'(bus.resp_err), 0);
    check("wd2_sum", 64'(bus.resp_sum), 64'h777);
    check("wd2_carry", 64'(bus.resp_carry), 1);
    bus.resp_ready = 4'b0100;
    cyc();
    bus.resp_ready = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
